// File: rtl/rf_arbiter.sv
// rtl/rf_arbiter.sv - core/debug round-robin arbiter for a shared register-file port.
// Optional RF_ARBITER_PAIR_GUARD_EN: blocks inc/dec on an odd pair index and flags the owner.
module rf_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c_req,
    input  logic       d_req,
    input  logic [3:0] c_sel,
    input  logic [3:0] d_sel,
    input  logic [3:0] c_psel,
    input  logic [3:0] d_psel,
    input  logic [7:0] c_wdata,
    input  logic [7:0] d_wdata,
    input  logic       c_we,
    input  logic       d_we,
    input  logic       c_inc,
    input  logic       d_inc,
    input  logic       c_dec,
    input  logic       d_dec,
    output logic       c_gnt,
    output logic       d_gnt,
    output logic       c_err,
    output logic       d_err,
    output logic [3:0] rf_inSelect,
    output logic [3:0] rf_outBselect,
    output logic [7:0] rf_in,
    output logic       rf_write_en,
    output logic       rf_inc,
    output logic       rf_dec
);

    typedef enum logic [1:0] {IDLE, CORE, DBG} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [7:0] hold_q;
    logic       rr_dbg_q;

    logic       own_req, own_we, own_inc, own_dec;
    logic [3:0] own_sel, own_psel;
    logic [7:0] own_wdata;
    logic       active, pair_hit, odd_hit, err_evt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (c_req && d_req) state_d = rr_dbg_q ? DBG : CORE;
                else if (c_req)     state_d = CORE;
                else if (d_req)     state_d = DBG;
            end
            CORE: begin
                if (c_req) begin
                    if (d_req && hold_q == HOLD_LAST) state_d = DBG;
                end else begin
                    state_d = d_req ? DBG : IDLE;
                end
            end
            DBG: begin
                if (d_req) begin
                    if (c_req && hold_q == HOLD_LAST) state_d = CORE;
                end else begin
                    state_d = c_req ? CORE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // rr_dbg_q set means debug wins the next IDLE tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= 8'd0;
            rr_dbg_q <= 1'b0;
            c_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            c_err    <= 1'b0;
            d_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            c_gnt   <= (state_d == CORE);
            d_gnt   <= (state_d == DBG);
            if (state_d != state_q) begin
                hold_q <= 8'd0;
                if (state_d == CORE) rr_dbg_q <= 1'b1;
                if (state_d == DBG)  rr_dbg_q <= 1'b0;
            end else if (state_q != IDLE && hold_q != HOLD_LAST) begin
                hold_q <= hold_q + 8'd1;
            end
            if (err_evt && state_q == CORE) c_err <= 1'b1;
            if (err_evt && state_q == DBG)  d_err <= 1'b1;
        end
    end

    always_comb begin
        own_req   = 1'b0;
        own_we    = 1'b0;
        own_inc   = 1'b0;
        own_dec   = 1'b0;
        own_sel   = 4'd0;
        own_psel  = 4'd0;
        own_wdata = 8'd0;
        case (state_q)
            CORE: begin
                own_req   = c_req;
                own_we    = c_we;
                own_inc   = c_inc;
                own_dec   = c_dec;
                own_sel   = c_sel;
                own_psel  = c_psel;
                own_wdata = c_wdata;
            end
            DBG: begin
                own_req   = d_req;
                own_we    = d_we;
                own_inc   = d_inc;
                own_dec   = d_dec;
                own_sel   = d_sel;
                own_psel  = d_psel;
                own_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    // A same-register write plus inc/dec is ambiguous: the write wins and it is flagged.
    always_comb begin
        active   = own_req && !rst;
        pair_hit = own_we && (own_inc || own_dec) && (own_sel == own_psel);
`ifdef RF_ARBITER_PAIR_GUARD_EN
        odd_hit  = (own_inc || own_dec) && own_psel[0];
`else
        odd_hit  = 1'b0;
`endif
        err_evt       = active && (pair_hit || odd_hit);
        rf_write_en   = active && own_we;
        rf_inc        = active && own_inc && !pair_hit && !odd_hit;
        rf_dec        = active && own_dec && !own_inc && !pair_hit && !odd_hit;
        rf_inSelect   = active ? own_sel   : 4'd0;
        rf_outBselect = active ? own_psel  : 4'd0;
        rf_in         = active ? own_wdata : 8'd0;
    end

endmodule
